control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle sequencer for the RV32I core. It drives the datapath strobes and select lines consumed through `control_signals_if`: PC/IR/RD/CSR writes, memory read/write, address and ALU operand selects. It sits between the decoder fields (opcode, funct3), the memory handshake and the debug module. Compared with the fixed sequencer, it adds a parametrised memory-timeout fault, optional CSR support, a configurable reset-into-halt mode, and a debug halt/resume/single-step handshake.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: cycles allowed per memory access before fault; 0 disables the timeout.
- `CSR_EN`, 1: when 1, SYSTEM/CSR instructions execute; when 0, they are illegal.
- `RESET_HALTED`, 0: when 1, the FSM leaves reset in HALT; when 0, in FETCH.

Ports (clock `clk`; reset `rst`, asynchronous, active-high):
- `clk` in 1: core clock.
- `rst` in 1: asynchronous active-high reset.
- `opcode` in 7: IR[6:0].
- `f3` in 3: IR[14:12].
- `cond` in 1: branch comparison result from the ALU.
- `mem_complete` in 1: the current memory access finishes this cycle.
- `halt_req`, `resume_req`, `step_req` in 1 each: debug requests. These are levels, sampled as described in Operation.
- `halted` out 1: the FSM is in HALT or FAULT.
- `write_pc_ne`, `write_pc_ex`, `write_pc`, `write_ir`, `write_rd`, `write_csr` out 1 each: write strobes. `write_pc = write_pc_ne | write_pc_ex`.
- `mem_read`, `mem_write` out 1 each: memory request.
- `addr_sel` out 1: 0 = ALU, 1 = PC.
- `rd_sel` out 2: 00 = ALU, 01 = MEM, 10 = CSR.
- `alu_insel1` out 2: 00 = RS, 01 = PC, 10 = ZR.
- `alu_insel2` out 2: 00 = RS, 01 = IM, 10 = IS.
- `bus_fault`, `illegal_insn` out 1 each: sticky fault flags.

## Operation
- States are FETCH, EXEC, MEM, HALT and FAULT.
- Outputs are combinational from the state, `opcode`, `f3`, `cond` and `mem_complete`. All strobes are 0 outside the rules below.
- **FETCH**
  - Drives `mem_read`=1, `addr_sel`=PC.
  - On `mem_complete`: `write_ir`=1, next state EXEC.
- **EXEC**
  - OP: `write_rd`, ALU sources RS/RS.
  - OP-IMM: `write_rd`, ALU sources RS/IM.
  - LUI: `write_rd`, ALU sources ZR/IM.
  - AUIPC: `write_rd`, ALU sources PC/IM.
  - For these four, also `write_pc_ne`, then go to FETCH.
  - JAL: ALU PC/IM, `write_pc_ex`, `write_rd`.
  - JALR: ALU RS/IM, `write_pc_ex`, `write_rd`.
  - BRANCH: ALU PC/IM; `write_pc_ex` if `cond`, otherwise `write_pc_ne`.
  - LOAD or STORE: next state MEM, no strobes.
  - SYSTEM with `CSR_EN` set and `f3`≠0: `write_csr`, `write_rd`, `rd_sel`=CSR, `write_pc_ne`.
  - Any other opcode, or SYSTEM with `CSR_EN`=0: set `illegal_insn`, go to FAULT, no strobes.
- **MEM**
  - Drives `addr_sel`=ALU, ALU sources RS/IM. LOAD drives `mem_read`; STORE drives `mem_write`.
  - On `mem_complete`: `write_pc_ne`; a load also drives `write_rd` with `rd_sel`=MEM.
- **Instruction boundary**: any cycle that asserts `write_pc`.
  - Next state is HALT if `halt_req`=1 or `step_pending`=1; otherwise FETCH.
  - `step_pending` clears at the boundary.
- **HALT**
  - `resume_req`=1 goes to FETCH.
  - Otherwise, `step_req`=1 goes to FETCH and sets `step_pending`.
  - `resume_req` has priority over `step_req`.
- **FAULT**: behaves like HALT, and leaving it clears `bus_fault` and `illegal_insn`.
- **Timeout**
  - A counter of width `$clog2(MEM_TIMEOUT+1)` clears on entry to FETCH or MEM and on `mem_complete`. It increments each cycle in FETCH or MEM without `mem_complete` and saturates.
  - When count = `MEM_TIMEOUT`-1 and `mem_complete`=0: set `bus_fault` and go to FAULT. No write strobe is asserted in that cycle.
  - `mem_complete` in the same cycle wins, so no fault is raised.
- `halt_req` in FETCH or MEM waits for the instruction boundary. Accesses are never aborted.

## Timing
- **Reset values**
  - State is HALT if `RESET_HALTED`, else FETCH.
  - `step_pending`, counter, `bus_fault` and `illegal_insn` are 0.
  - Outputs follow the reset state: FETCH gives `mem_read`=1, `addr_sel`=1; HALT gives `halted`=1 and all strobes 0.
- **Latency**
  - ALU-class instruction with 1-cycle memory: 2 cycles.
  - Load or store: 3 cycles plus memory wait states.
- **Debug handshake**
  - `halted` rises the cycle after the boundary.
  - Resume takes effect the cycle after it is sampled in HALT.
  - One `step_req` executes exactly one instruction.
- **Reset during MEM** aborts immediately. There are no further strobes.

## Structure
- `control_pkg` holds the state enum `ctrl_state_t`, the select encodings (ADDR/RD/ALU1/ALU2) and the opcode constants.
- Sub-module `mem_timeout_counter` (parameter `MEM_TIMEOUT`; ports `clk`, `rst`, `clear`, `enable`, `expired`) isolates the saturating counter. `MEM_TIMEOUT`=0 ties `expired` to 0.

## Test plan
- **ALU instruction**: reset with `RESET_HALTED`=0, opcode 0010011, `mem_complete`=1 every cycle → `write_ir` in cycle 0; in cycle 1 `write_rd`=1, `write_pc_ne`=1, `alu_insel2`=01; back in FETCH in cycle 2.
- **Load with wait states**: opcode 0000011 with `mem_complete` held low for 3 cycles in MEM → `mem_read`=1, `addr_sel`=0 for 4 cycles; the final cycle has `write_rd`=1, `rd_sel`=01 and `write_pc_ne`=1.
- **Branch**: opcode 1100011 with `cond`=1 → `write_pc_ex`=1, `write_pc_ne`=0. With `cond`=0 → the reverse.
- **Timeout**: `MEM_TIMEOUT`=4 and `mem_complete` stuck at 0 in FETCH → FAULT entered after 4 cycles, `bus_fault`=1, `halted`=1. A following `resume_req` clears `bus_fault` and returns to FETCH.
- **Debug step and halt**: `halt_req` asserted mid-load → halts only after `write_pc`. A `step_req` pulse then executes one OP instruction and returns to HALT. With both `resume_req` and `step_req` asserted → free-running, `step_pending`=0.
- **Illegal and CSR**: `CSR_EN`=0 with opcode 1110011 → `illegal_insn`=1, FAULT, `write_rd`=0. Reset asserted mid-MEM → all strobes 0 asynchronously.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
package control_pkg;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    HALT,
    FAULT
  } ctrl_state_t;

  localparam logic       ADDR_ALU = 1'b0;
  localparam logic       ADDR_PC  = 1'b1;

  localparam logic [1:0] RD_ALU   = 2'b00;
  localparam logic [1:0] RD_MEM   = 2'b01;
  localparam logic [1:0] RD_CSR   = 2'b10;

  localparam logic [1:0] ALU1_RS  = 2'b00;
  localparam logic [1:0] ALU1_PC  = 2'b01;
  localparam logic [1:0] ALU1_ZR  = 2'b10;

  localparam logic [1:0] ALU2_RS  = 2'b00;
  localparam logic [1:0] ALU2_IM  = 2'b01;
  localparam logic [1:0] ALU2_IS  = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait-state counter; expired flags the last allowed cycle of an access.
module mem_timeout_counter #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clear, enable};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
      localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count <= '0;
        end else if (clear) begin
          count <= '0;
        end else if (enable && (count != '1)) begin
          count <= count + 1'b1;
        end
      end

      assign expired = (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencer: datapath strobes, memory timeout fault and
// debug halt/resume/single-step handshake.
module control_fsm
  import control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CSR_EN       = 1,
  parameter int unsigned RESET_HALTED = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       cond,
  input  logic       mem_complete,
  input  logic       halt_req,
  input  logic       resume_req,
  input  logic       step_req,
  output logic       halted,
  output logic       write_pc_ne,
  output logic       write_pc_ex,
  output logic       write_pc,
  output logic       write_ir,
  output logic       write_rd,
  output logic       write_csr,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic [1:0] rd_sel,
  output logic [1:0] alu_insel1,
  output logic [1:0] alu_insel2,
  output logic       bus_fault,
  output logic       illegal_insn
);

  ctrl_state_t state, next_state;
  logic        step_pending;
  logic        raise_bus, raise_ill, step_set;
  logic        in_access, tmo_expired;

  assign in_access = (state == FETCH) || (state == MEM);
  assign halted    = (state == HALT) || (state == FAULT);
  assign write_pc  = write_pc_ne | write_pc_ex;

  // Holding the counter clear outside FETCH/MEM is what makes it start
  // from zero on every entry to an access state.
  mem_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (mem_complete | ~in_access),
    .enable (in_access & ~mem_complete),
    .expired(tmo_expired)
  );

  always_comb begin
    next_state  = state;
    raise_bus   = 1'b0;
    raise_ill   = 1'b0;
    step_set    = 1'b0;
    write_pc_ne = 1'b0;
    write_pc_ex = 1'b0;
    write_ir    = 1'b0;
    write_rd    = 1'b0;
    write_csr   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    addr_sel    = ADDR_ALU;
    rd_sel      = RD_ALU;
    alu_insel1  = ALU1_RS;
    alu_insel2  = ALU2_RS;

    case (state)
      FETCH: begin
        mem_read = 1'b1;
        addr_sel = ADDR_PC;
        if (mem_complete) begin
          write_ir   = 1'b1;
          next_state = EXEC;
        end else if (tmo_expired) begin
          raise_bus  = 1'b1;
          next_state = FAULT;
        end
      end
      EXEC: begin
        case (opcode)
          OPC_OP: begin
            write_rd    = 1'b1;
            write_pc_ne = 1'b1;
          end
          OPC_OP_IMM: begin
            write_rd    = 1'b1;
            write_pc_ne = 1'b1;
            alu_insel2  = ALU2_IM;
          end
          OPC_LUI: begin
            write_rd    = 1'b1;
            write_pc_ne = 1'b1;
            alu_insel1  = ALU1_ZR;
            alu_insel2  = ALU2_IM;
          end
          OPC_AUIPC: begin
            write_rd    = 1'b1;
            write_pc_ne = 1'b1;
            alu_insel1  = ALU1_PC;
            alu_insel2  = ALU2_IM;
          end
          OPC_JAL: begin
            write_rd    = 1'b1;
            write_pc_ex = 1'b1;
            alu_insel1  = ALU1_PC;
            alu_insel2  = ALU2_IM;
          end
          OPC_JALR: begin
            write_rd    = 1'b1;
            write_pc_ex = 1'b1;
            alu_insel2  = ALU2_IM;
          end
          OPC_BRANCH: begin
            alu_insel1  = ALU1_PC;
            alu_insel2  = ALU2_IM;
            write_pc_ex = cond;
            write_pc_ne = ~cond;
          end
          OPC_LOAD, OPC_STORE: next_state = MEM;
          OPC_SYSTEM: begin
            if ((CSR_EN != 0) && (f3 != '0)) begin
              write_csr   = 1'b1;
              write_rd    = 1'b1;
              rd_sel      = RD_CSR;
              write_pc_ne = 1'b1;
            end else begin
              raise_ill  = 1'b1;
              next_state = FAULT;
            end
          end
          default: begin
            raise_ill  = 1'b1;
            next_state = FAULT;
          end
        endcase
      end
      MEM: begin
        addr_sel   = ADDR_ALU;
        alu_insel2 = ALU2_IM;
        mem_read   = (opcode == OPC_LOAD);
        mem_write  = (opcode == OPC_STORE);
        if (mem_complete) begin
          write_pc_ne = 1'b1;
          if (opcode == OPC_LOAD) begin
            write_rd = 1'b1;
            rd_sel   = RD_MEM;
          end
        end else if (tmo_expired) begin
          raise_bus  = 1'b1;
          next_state = FAULT;
        end
      end
      HALT, FAULT: begin
        if (resume_req) begin
          next_state = FETCH;
        end else if (step_req) begin
          next_state = FETCH;
          step_set   = 1'b1;
        end
      end
      default: next_state = FETCH;
    endcase

    // Any PC write retires the instruction; debug requests are honoured only here.
    if (write_pc_ne | write_pc_ex) begin
      next_state = (halt_req || step_pending) ? HALT : FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= (RESET_HALTED != 0) ? HALT : FETCH;
      step_pending <= 1'b0;
      bus_fault    <= 1'b0;
      illegal_insn <= 1'b0;
    end else begin
      state <= next_state;
      if (write_pc) begin
        step_pending <= 1'b0;
      end else if (step_set) begin
        step_pending <= 1'b1;
      end
      if ((state == FAULT) && (next_state != FAULT)) begin
        bus_fault    <= 1'b0;
        illegal_insn <= 1'b0;
      end else begin
        if (raise_bus) bus_fault    <= 1'b1;
        if (raise_ill) illegal_insn <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: two configurations, per-cycle expected output vectors.
module tb_control_fsm;

  typedef struct packed {
    logic       halted;
    logic       pc_ne;
    logic       pc_ex;
    logic       pc;
    logic       ir;
    logic       rd;
    logic       csr;
    logic       mrd;
    logic       mwr;
    logic       asel;
    logic [1:0] rsel;
    logic [1:0] a1;
    logic [1:0] a2;
    logic       bf;
    logic       ill;
  } out_t;

  typedef struct {
    string tag;
    bit    dut_b;
    out_t  exp;
  } sb_t;

  typedef struct {
    logic [6:0] op;
    logic [1:0] a1;
    logic [1:0] a2;
    bit         ex;
  } row_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] opcode;
  logic [2:0] f3;
  logic       cond, mem_complete, halt_req, resume_req, step_req;

  logic       a_halted, a_pc_ne, a_pc_ex, a_pc, a_ir, a_rd, a_csr, a_mrd, a_mwr, a_asel, a_bf, a_ill;
  logic [1:0] a_rsel, a_a1, a_a2;
  logic       b_halted, b_pc_ne, b_pc_ex, b_pc, b_ir, b_rd, b_csr, b_mrd, b_mwr, b_asel, b_bf, b_ill;
  logic [1:0] b_rsel, b_a1, b_a2;
  out_t       oa, ob;

  assign oa = {a_halted, a_pc_ne, a_pc_ex, a_pc, a_ir, a_rd, a_csr, a_mrd, a_mwr, a_asel,
               a_rsel, a_a1, a_a2, a_bf, a_ill};
  assign ob = {b_halted, b_pc_ne, b_pc_ex, b_pc, b_ir, b_rd, b_csr, b_mrd, b_mwr, b_asel,
               b_rsel, b_a1, b_a2, b_bf, b_ill};

  control_fsm #(.MEM_TIMEOUT(4), .CSR_EN(1), .RESET_HALTED(0)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .cond(cond), .mem_complete(mem_complete),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .halted(a_halted), .write_pc_ne(a_pc_ne), .write_pc_ex(a_pc_ex), .write_pc(a_pc),
    .write_ir(a_ir), .write_rd(a_rd), .write_csr(a_csr), .mem_read(a_mrd), .mem_write(a_mwr),
    .addr_sel(a_asel), .rd_sel(a_rsel), .alu_insel1(a_a1), .alu_insel2(a_a2),
    .bus_fault(a_bf), .illegal_insn(a_ill)
  );

  control_fsm #(.MEM_TIMEOUT(255), .CSR_EN(0), .RESET_HALTED(1)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .cond(cond), .mem_complete(mem_complete),
    .halt_req(halt_req), .resume_req(resume_req), .step_req(step_req),
    .halted(b_halted), .write_pc_ne(b_pc_ne), .write_pc_ex(b_pc_ex), .write_pc(b_pc),
    .write_ir(b_ir), .write_rd(b_rd), .write_csr(b_csr), .mem_read(b_mrd), .mem_write(b_mwr),
    .addr_sel(b_asel), .rd_sel(b_rsel), .alu_insel1(b_a1), .alu_insel2(b_a2),
    .bus_fault(b_bf), .illegal_insn(b_ill)
  );

  int   n_vec = 0;
  int   n_err = 0;
  sb_t  sbq[$];
  sb_t  cur;
  row_t tab[5];

  task automatic check_vec(input string tag, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      cur = sbq.pop_front();
      check_vec(cur.tag, cur.dut_b ? ob : oa, cur.exp);
    end
  end

  function automatic out_t f_fetch(bit done);
    out_t o = '0;
    o.mrd  = 1'b1;
    o.asel = 1'b1;
    o.ir   = done;
    return o;
  endfunction

  function automatic out_t f_exec(logic [1:0] a1, logic [1:0] a2, bit ne, bit ex, bit rd);
    out_t o = '0;
    o.a1    = a1;
    o.a2    = a2;
    o.pc_ne = ne;
    o.pc_ex = ex;
    o.pc    = ne | ex;
    o.rd    = rd;
    return o;
  endfunction

  function automatic out_t f_mem(bit load, bit done);
    out_t o = '0;
    o.a2  = 2'b01;
    o.mrd = load;
    o.mwr = !load;
    if (done) begin
      o.pc_ne = 1'b1;
      o.pc    = 1'b1;
      o.rd    = load;
      o.rsel  = load ? 2'b01 : 2'b00;
    end
    return o;
  endfunction

  function automatic out_t f_halt(bit bf, bit ill);
    out_t o = '0;
    o.halted = 1'b1;
    o.bf     = bf;
    o.ill    = ill;
    return o;
  endfunction

  // Drive one cycle of inputs, queue the expected outputs, advance to just after the next edge.
  task automatic cyc(input bit dutb, input string tag, input logic [6:0] op, input logic [2:0] fn3,
                     input logic c, input logic mc, input logic hr, input logic rr, input logic sr,
                     input out_t e);
    sb_t s;
    opcode = op; f3 = fn3; cond = c; mem_complete = mc;
    halt_req = hr; resume_req = rr; step_req = sr;
    s.tag = tag; s.dut_b = dutb; s.exp = e;
    sbq.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic ca(input string tag, input logic [6:0] op, input logic mc, input out_t e);
    cyc(1'b0, tag, op, 3'b000, 1'b0, mc, 1'b0, 1'b0, 1'b0, e);
  endtask

  initial begin
    out_t e;
    rst = 1'b1; opcode = '0; f3 = '0; cond = 1'b0; mem_complete = 1'b0;
    halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    tab[0] = '{7'b0110011, 2'b00, 2'b00, 1'b0};
    tab[1] = '{7'b0110111, 2'b10, 2'b01, 1'b0};
    tab[2] = '{7'b0010111, 2'b01, 2'b01, 1'b0};
    tab[3] = '{7'b1101111, 2'b01, 2'b01, 1'b1};
    tab[4] = '{7'b1100111, 2'b00, 2'b01, 1'b1};
    @(posedge clk);
    #1;

    ca("rst_a", OP_OP, 1'b0, f_fetch(1'b0));
    cyc(1'b1, "rst_b", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f_halt(1'b0, 1'b0));
    rst = 1'b0;

    ca("alu_fetch", OP_OPIMM, 1'b1, f_fetch(1'b1));
    ca("alu_exec", OP_OPIMM, 1'b1, f_exec(2'b00, 2'b01, 1'b1, 1'b0, 1'b1));
    ca("alu_back", OP_OPIMM, 1'b0, f_fetch(1'b0));

    for (int i = 0; i < 5; i++) begin
      ca($sformatf("tab%0d_fetch", i), tab[i].op, 1'b1, f_fetch(1'b1));
      ca($sformatf("tab%0d_exec", i), tab[i].op, 1'b1,
         f_exec(tab[i].a1, tab[i].a2, !tab[i].ex, tab[i].ex, 1'b1));
    end

    ca("ld_fetch", OP_LOAD, 1'b1, f_fetch(1'b1));
    ca("ld_exec", OP_LOAD, 1'b0, '0);
    for (int i = 0; i < 3; i++) ca($sformatf("ld_wait%0d", i), OP_LOAD, 1'b0, f_mem(1'b1, 1'b0));
    ca("ld_done", OP_LOAD, 1'b1, f_mem(1'b1, 1'b1));

    ca("st_fetch", OP_STORE, 1'b1, f_fetch(1'b1));
    ca("st_exec", OP_STORE, 1'b1, '0);
    ca("st_done", OP_STORE, 1'b1, f_mem(1'b0, 1'b1));

    cyc(1'b0, "br1_fetch", OP_BRANCH, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, f_fetch(1'b1));
    cyc(1'b0, "br1_exec", OP_BRANCH, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
        f_exec(2'b01, 2'b01, 1'b0, 1'b1, 1'b0));
    cyc(1'b0, "br0_fetch", OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_fetch(1'b1));
    cyc(1'b0, "br0_exec", OP_BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
        f_exec(2'b01, 2'b01, 1'b1, 1'b0, 1'b0));

    cyc(1'b0, "csr_fetch", OP_SYSTEM, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_fetch(1'b1));
    e = f_exec(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
    e.csr  = 1'b1;
    e.rsel = 2'b10;
    cyc(1'b0, "csr_exec", OP_SYSTEM, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, e);

    ca("dbg_fetch", OP_LOAD, 1'b1, f_fetch(1'b1));
    ca("dbg_exec", OP_LOAD, 1'b0, '0);
    cyc(1'b0, "dbg_wait", OP_LOAD, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, f_mem(1'b1, 1'b0));
    cyc(1'b0, "dbg_done", OP_LOAD, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, f_mem(1'b1, 1'b1));
    ca("dbg_halted", OP_OP, 1'b0, f_halt(1'b0, 1'b0));
    ca("dbg_hold", OP_OP, 1'b1, f_halt(1'b0, 1'b0));
    cyc(1'b0, "dbg_step", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, f_halt(1'b0, 1'b0));
    ca("stp_fetch", OP_OP, 1'b1, f_fetch(1'b1));
    ca("stp_exec", OP_OP, 1'b1, f_exec(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
    ca("stp_halt", OP_OP, 1'b1, f_halt(1'b0, 1'b0));
    cyc(1'b0, "both_req", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, f_halt(1'b0, 1'b0));
    ca("run_fetch", OP_OP, 1'b1, f_fetch(1'b1));
    ca("run_exec", OP_OP, 1'b1, f_exec(2'b00, 2'b00, 1'b1, 1'b0, 1'b1));
    ca("run_fetch2", OP_OP, 1'b0, f_fetch(1'b0));

    rst = 1'b1;
    ca("rst_a2", OP_OP, 1'b0, f_fetch(1'b0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) ca($sformatf("to_wait%0d", i), OP_OP, 1'b0, f_fetch(1'b0));
    ca("to_fault", OP_OP, 1'b0, f_halt(1'b1, 1'b0));
    cyc(1'b0, "to_resume", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f_halt(1'b1, 1'b0));
    ca("to_clear", OP_OP, 1'b1, f_fetch(1'b1));
    ca("ill_exec", 7'b0000000, 1'b0, '0);
    ca("ill_fault", 7'b0000000, 1'b0, f_halt(1'b0, 1'b1));

    rst = 1'b1;
    cyc(1'b1, "b_rst", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f_halt(1'b0, 1'b0));
    rst = 1'b0;
    cyc(1'b1, "b_idle", OP_OP, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_halt(1'b0, 1'b0));
    cyc(1'b1, "b_resume", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f_halt(1'b0, 1'b0));
    cyc(1'b1, "b_fetch", OP_SYSTEM, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_fetch(1'b1));
    cyc(1'b1, "b_csr_ill", OP_SYSTEM, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, "b_fault", OP_SYSTEM, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_halt(1'b0, 1'b1));
    cyc(1'b1, "b_resume2", OP_OP, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, f_halt(1'b0, 1'b1));
    cyc(1'b1, "b_ld_fetch", OP_LOAD, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_fetch(1'b1));
    cyc(1'b1, "b_ld_exec", OP_LOAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, "b_ld_mem", OP_LOAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f_mem(1'b1, 1'b0));
    rst = 1'b1;
    cyc(1'b1, "b_rst_mem", OP_LOAD, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f_halt(1'b0, 1'b0));
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
